// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined signed/unsigned multiplier.
// The per-stage payload is {neg, partial magnitude}; its width follows the
// operand width, so the packed struct itself is declared in the top module
// from payload_width(); the package provides the sizing helpers and the
// slot state encoding used by every register slice.
package mult_pkg;

    localparam int MIN_STAGES = 2;

    // Full product width for w-bit operands.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // Bits in one stage payload: negate flag plus partial magnitude.
    function automatic int payload_width(input int w);
        return 1 + prod_width(w);
    endfunction

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/pipelined_signed_multiplier_if.sv
// Producer/consumer bus of the multiplier: operand handshake in, product
// handshake out, plus an activity indicator.
interface pipelined_signed_multiplier_if
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             a;
    logic [WIDTH-1:0]             b;
    logic                         signed_mode;
    logic                         out_valid;
    logic                         out_ready;
    logic [prod_width(WIDTH)-1:0] product;
    logic                         busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/mult_pipe_slice.sv
// One elastic register slice. It accepts whenever it is empty or its own
// content leaves this cycle, so bubbles collapse under downstream stalls.
// Data and valid are registered; ready is combinational from downstream.
module mult_pipe_slice
    import mult_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    slot_state_t   state_r;
    logic [PW-1:0] data_r;
    logic          ready_s;

    // Slice can take new content when empty or when its content drains now.
    always_comb begin
        ready_s = 1'b0;
        if (state_r == SLOT_EMPTY) begin
            ready_s = 1'b1;
        end else begin
            ready_s = out_ready;
        end
    end

    // Load from upstream when ready; otherwise hold data and state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= SLOT_EMPTY;
            data_r  <= '0;
        end else if (ready_s) begin
            if (in_valid) begin
                state_r <= SLOT_FULL;
                data_r  <= in_data;
            end else begin
                state_r <= SLOT_EMPTY;
            end
        end
    end

    assign in_ready  = ready_s;
    assign out_valid = (state_r == SLOT_FULL);
    assign out_data  = data_r;

endmodule

// File: rtl/pipelined_signed_multiplier.sv
// Elastic, fully pipelined WIDTH x WIDTH multiplier with per-transaction
// signed/unsigned selection. Stage 0 holds operand magnitudes and the
// result sign, stage 1 forms the unsigned magnitude product, and the last
// stage re-applies the sign. With STAGES = 2 the multiply and the sign fix
// share the last stage. Accept-to-output latency is STAGES cycles.
module pipelined_signed_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    pipelined_signed_multiplier_if.slave bus
);

    localparam int PW = prod_width(WIDTH);
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    ONE_P = {{(PW-1){1'b0}}, 1'b1};

    // In stage 0 the magnitude field carries {mag_a, mag_b}; from stage 1 on
    // it carries the (eventually signed) 2*WIDTH-bit product.
    typedef struct packed {
        logic          neg;
        logic [PW-1:0] mag;
    } stage_payload_t;

    localparam int SW = $bits(stage_payload_t);

    // Unsigned product of the two operand magnitudes held in stage 0.
    function automatic stage_payload_t multiply_mags(input stage_payload_t p);
        stage_payload_t res;
        res.neg = p.neg;
        res.mag = {{WIDTH{1'b0}}, p.mag[PW-1:WIDTH]} * {{WIDTH{1'b0}}, p.mag[WIDTH-1:0]};
        return res;
    endfunction

    // Two's-complement negate when the sign flag is set; zero stays zero.
    function automatic stage_payload_t apply_sign(input stage_payload_t p);
        stage_payload_t res;
        res.neg = p.neg;
        if (p.neg) begin
            res.mag = ~p.mag + ONE_P;
        end else begin
            res.mag = p.mag;
        end
        return res;
    endfunction

    stage_payload_t    op_payload_s;
    logic [WIDTH-1:0]  mag_a_s;
    logic [WIDTH-1:0]  mag_b_s;
    logic              neg_s;
    logic [STAGES-1:0] valid_vec_s;
    stage_payload_t    last_s;
    logic              unused_neg_s;

    // Operand conditioning: magnitudes and result sign for stage 0.
    always_comb begin
        mag_a_s = bus.a;
        mag_b_s = bus.b;
        neg_s   = 1'b0;
        if (bus.signed_mode) begin
            neg_s = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            if (bus.a[WIDTH-1]) begin
                mag_a_s = ~bus.a + ONE_W;
            end else begin
                mag_a_s = bus.a;
            end
            if (bus.b[WIDTH-1]) begin
                mag_b_s = ~bus.b + ONE_W;
            end else begin
                mag_b_s = bus.b;
            end
        end else begin
            neg_s   = 1'b0;
            mag_a_s = bus.a;
            mag_b_s = bus.b;
        end
        op_payload_s.neg = neg_s;
        op_payload_s.mag = {mag_a_s, mag_b_s};
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_payload_t din_s;
        stage_payload_t dout_s;
        logic           up_valid_s;
        logic           valid_s;
        logic           ready_s;
        logic           down_ready_s;

        if (k == 0) begin : g_operands
            assign up_valid_s = bus.in_valid;
            assign din_s      = op_payload_s;
        end else if (k == 1 && k == STAGES - 1) begin : g_mul_sign
            assign up_valid_s = g_stage[k-1].valid_s;
            assign din_s      = apply_sign(multiply_mags(g_stage[k-1].dout_s));
        end else if (k == 1) begin : g_mul
            assign up_valid_s = g_stage[k-1].valid_s;
            assign din_s      = multiply_mags(g_stage[k-1].dout_s);
        end else if (k == STAGES - 1) begin : g_sign
            assign up_valid_s = g_stage[k-1].valid_s;
            assign din_s      = apply_sign(g_stage[k-1].dout_s);
        end else begin : g_carry
            assign up_valid_s = g_stage[k-1].valid_s;
            assign din_s      = g_stage[k-1].dout_s;
        end

        if (k == STAGES - 1) begin : g_tail
            assign down_ready_s = bus.out_ready;
        end else begin : g_link
            assign down_ready_s = g_stage[k+1].ready_s;
        end

        mult_pipe_slice #(
            .PW (SW)
        ) u_slice (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (up_valid_s),
            .in_ready  (ready_s),
            .in_data   (din_s),
            .out_valid (valid_s),
            .out_ready (down_ready_s),
            .out_data  (dout_s)
        );

        assign valid_vec_s[k] = valid_s;
    end

    assign last_s       = g_stage[STAGES-1].dout_s;
    assign unused_neg_s = last_s.neg;

    assign bus.in_ready  = g_stage[0].ready_s;
    assign bus.out_valid = g_stage[STAGES-1].valid_s;
    assign bus.product   = last_s.mag;
    assign bus.busy      = |valid_vec_s;

endmodule
